// File: rtl/video_in_pack.sv
// video_in_pack: samples video_gen on pix_en, packs PIX_PER_WORD pixels per FIFO word,
// and raises sticky line/frame geometry and FIFO overflow errors.
module video_in_pack #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4
) (
  input  logic                            clk,
  input  logic                            nRST,
  input  logic                            pix_en,
  input  logic                            line_valid,
  input  logic                            frame_valid,
  input  logic [PIX_W-1:0]                pixel_in,
  input  logic                            new_addr,
  input  logic                            single_shot,
  input  logic                            fifo_full,
  input  logic                            err_clr,
  output logic                            w_e,
  output logic [PIX_W*PIX_PER_WORD-1:0]   pixels_out,
  output logic                            frame_start,
  output logic                            frame_done,
  output logic                            err_line_long,
  output logic                            err_line_short,
  output logic                            err_frame_size,
  output logic                            err_overflow
);
  localparam int OUT_W  = PIX_W * PIX_PER_WORD;
  localparam int COL_W  = $clog2(WIDTH + 1);
  localparam int LINE_W = $clog2(HEIGHT + 2);

  // state     | meaning
  // S_IDLE    | not armed, waiting for new_addr
  // S_ARMED   | armed, waiting for a sample with fv low
  // S_SYNC    | at a frame gap, waiting for fv high
  // S_CAPTURE | capturing the active frame
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SYNC, S_CAPTURE} state_t;

  state_t              r_state, w_state_nxt;
  logic [COL_W-1:0]    r_col, w_slot;
  logic [LINE_W-1:0]   r_line, w_line_inc, w_line_after;
  logic                r_lv_prev;
  logic [OUT_W-1:0]    r_acc, w_word;
  logic                w_start, w_end, w_pix, w_line_end, w_store, w_fill;
  logic                w_set_long, w_set_short, w_set_size, w_set_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_pix       = 1'b0;
    w_line_end  = 1'b0;
    case (r_state)
      S_IDLE:    if (new_addr) w_state_nxt = S_ARMED;
      S_ARMED:   if (pix_en && !frame_valid) w_state_nxt = S_SYNC;
      S_SYNC: begin
        if (pix_en && frame_valid) begin
          w_state_nxt = S_CAPTURE;
          w_start     = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (pix_en) begin
          // fv dropping while lv is still high also closes the line
          w_line_end = r_lv_prev && (!line_valid || !frame_valid);
          w_pix      = line_valid && frame_valid;
          if (!frame_valid) begin
            w_end       = 1'b1;
            w_state_nxt = single_shot ? S_IDLE : S_SYNC;
          end
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_slot       = r_col % COL_W'(PIX_PER_WORD);
    w_store      = w_pix && (r_col < COL_W'(WIDTH)) && (r_line < LINE_W'(HEIGHT));
    w_fill       = w_store && (w_slot == COL_W'(PIX_PER_WORD - 1));
    w_line_inc   = (r_line == LINE_W'(HEIGHT + 1)) ? r_line : r_line + 1'b1;
    w_line_after = w_line_end ? w_line_inc : r_line;
    w_set_long   = w_pix && (r_col == COL_W'(WIDTH));
    w_set_short  = w_line_end && (r_col != COL_W'(WIDTH));
    w_set_size   = (w_pix && (r_line >= LINE_W'(HEIGHT))) ||
                   (w_end && (w_line_after != LINE_W'(HEIGHT)));
    w_set_ovf    = w_fill && fifo_full;
    w_word       = r_acc;
    for (int s = 0; s < PIX_PER_WORD; s++) begin
      if (w_slot == COL_W'(s)) w_word[OUT_W-1-s*PIX_W -: PIX_W] = pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state        <= S_IDLE;
      r_col          <= '0;
      r_line         <= '0;
      r_lv_prev      <= 1'b0;
      r_acc          <= '0;
      w_e            <= 1'b0;
      pixels_out     <= '0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      err_line_long  <= 1'b0;
      err_line_short <= 1'b0;
      err_frame_size <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      frame_start <= w_start;
      frame_done  <= w_end;
      w_e         <= w_fill && !fifo_full;
      if (w_fill && !fifo_full) pixels_out <= w_word;
      if (w_start) begin
        r_col     <= '0;
        r_line    <= '0;
        r_lv_prev <= 1'b0;
      end else if (r_state == S_CAPTURE && pix_en) begin
        r_lv_prev <= line_valid;
        if (w_line_end) begin
          r_col  <= '0;
          r_line <= w_line_inc;
        end else if (w_store) begin
          r_col <= r_col + 1'b1;
          r_acc <= w_word;
        end
      end
      // a new error in the same cycle as err_clr stays set
      err_line_long  <= w_set_long  | (err_line_long  & ~err_clr);
      err_line_short <= w_set_short | (err_line_short & ~err_clr);
      err_frame_size <= w_set_size  | (err_frame_size & ~err_clr);
      err_overflow   <= w_set_ovf   | (err_overflow   & ~err_clr);
    end
  end
endmodule

// File: tb/tb_video_in_pack.sv
// Self-checking bench for video_in_pack: table-driven frames, hand sequences for
// arming/reset/clear corner cases, and randomized frames against a frame-level model.
module tb_video_in_pack;
  localparam int WIDTH = 8, HEIGHT = 2, PIX_W = 8, PPW = 4;

  logic clk = 1'b0;
  logic nRST, pix_en, line_valid, frame_valid, new_addr, single_shot, fifo_full, err_clr;
  logic [PIX_W-1:0] pixel_in;
  logic w_e, frame_start, frame_done;
  logic err_line_long, err_line_short, err_frame_size, err_overflow;
  logic [PIX_W*PPW-1:0] pixels_out;

  always #5 clk = ~clk;

  video_in_pack #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .PIX_PER_WORD(PPW)) dut (
    .clk(clk), .nRST(nRST), .pix_en(pix_en), .line_valid(line_valid),
    .frame_valid(frame_valid), .pixel_in(pixel_in), .new_addr(new_addr),
    .single_shot(single_shot), .fifo_full(fifo_full), .err_clr(err_clr),
    .w_e(w_e), .pixels_out(pixels_out), .frame_start(frame_start),
    .frame_done(frame_done), .err_line_long(err_line_long),
    .err_line_short(err_line_short), .err_frame_size(err_frame_size),
    .err_overflow(err_overflow));

  int nchk = 0, nerr = 0;
  logic [31:0] expq[$];
  logic [31:0] wlog[$];
  int exp_starts = 0, exp_dones = 0, seen_starts = 0, seen_dones = 0;
  bit m_long, m_short, m_size, m_ovf;

  int g_nl;
  int g_lens[4];
  int g_full_pc = -1, g_clr_pc = -1, g_addr_pc = -1, g_rst_pc = -1;
  bit g_cap, g_seq, g_fall, g_rand_full;
  int g_duty = 1;

  typedef struct {
    int nl; int l0; int l1; int l2; int full_pc; int words;
    bit e_long; bit e_short; bit e_size; bit e_ovf;
  } vec_t;
  vec_t tv[6];
  logic [31:0] t1_words[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (frame_start) seen_starts++;
    if (frame_done) seen_dones++;
    if (w_e) begin
      wlog.push_back(pixels_out);
      if (expq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: got %0h expected no write at %0t", pixels_out, $time);
      end else begin
        chk("pixels_out", pixels_out, expq.pop_front());
      end
    end
  end

  task automatic vsample(input bit lv, input bit fv, input logic [7:0] px, input bit full,
                         input bit clr, input bit addr, input bit rst);
    for (int k = 0; k < g_duty - 1; k++) begin
      pix_en = 1'b0; line_valid = 1'($urandom); frame_valid = 1'($urandom);
      pixel_in = 8'($urandom); fifo_full = 1'($urandom); err_clr = 1'b0; new_addr = 1'b0;
      tick();
    end
    pix_en = 1'b1; line_valid = lv; frame_valid = fv; pixel_in = px; fifo_full = full;
    err_clr = clr; new_addr = addr; nRST = !rst;
    tick();
    pix_en = 1'b0; err_clr = 1'b0; new_addr = 1'b0; nRST = 1'b1; fifo_full = 1'b0;
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, "_long"},  err_line_long,  m_long);
    chk({nm, "_short"}, err_line_short, m_short);
    chk({nm, "_size"},  err_frame_size, m_size);
    chk({nm, "_ovf"},   err_overflow,   m_ovf);
  endtask

  // Frame-level model: pixel p of line l lands in the word only if l<HEIGHT and p<WIDTH;
  // every 4th accepted pixel completes a word, which is lost if the FIFO is full then.
  task automatic run_frame();
    bit cap = g_cap;
    int pc = 0;
    logic [7:0] px;
    logic [7:0] grp [4];
    bit full, clr, addr, rst, fill, last;
    vsample(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    vsample(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    vsample(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("frame_start_pulse", frame_start, cap);
    if (cap) exp_starts++;
    for (int l = 0; l < g_nl; l++) begin
      for (int p = 0; p < g_lens[l]; p++) begin
        px   = g_seq ? 8'(pc) : 8'($urandom);
        full = (pc == g_full_pc) || (g_rand_full && ($urandom_range(0, 7) == 0));
        clr  = (pc == g_clr_pc);
        addr = (pc == g_addr_pc);
        rst  = (pc == g_rst_pc);
        fill = 1'b0;
        if (rst) begin
          cap = 1'b0; m_long = 0; m_short = 0; m_size = 0; m_ovf = 0;
        end
        if (clr) begin
          m_long = 0; m_short = 0; m_size = 0; m_ovf = 0;
        end
        if (cap) begin
          if (l >= HEIGHT) m_size = 1;
          else if (p >= WIDTH) m_long = 1;
          else begin
            grp[p % PPW] = px;
            if (p % PPW == PPW - 1) begin
              if (full) m_ovf = 1;
              else begin
                fill = 1'b1;
                expq.push_back({grp[0], grp[1], grp[2], grp[3]});
              end
            end
          end
        end
        vsample(1'b1, 1'b1, px, full, clr, addr, rst);
        chk("w_e_latency", w_e, fill);
        pc++;
      end
      last = (l == g_nl - 1);
      if (cap && (l >= HEIGHT || g_lens[l] < WIDTH)) m_short = 1;
      if (!(last && g_fall)) vsample(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (cap) begin
      if (g_nl != HEIGHT) m_size = 1;
      exp_dones++;
    end
    vsample(g_fall, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("frame_done_pulse", frame_done, cap);
    tick();
    tick();
    chk("words_missing", expq.size(), 0);
    chk("frame_start_count", seen_starts, exp_starts);
    chk("frame_done_count", seen_dones, exp_dones);
    chk_flags("flags");
  endtask

  task automatic set_frame(input int nl, input int l0, input int l1, input int l2);
    g_nl = nl; g_lens[0] = l0; g_lens[1] = l1; g_lens[2] = l2; g_lens[3] = 0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_long = 0; m_short = 0; m_size = 0; m_ovf = 0;
    chk_flags("after_clr");
  endtask

  task automatic chk_t1_words(input string nm);
    chk({nm, "_count"}, wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk({nm, "_word"}, (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF, t1_words[i]);
  endtask

  initial begin
    tv[0] = '{nl:2, l0:8, l1:8, l2:0, full_pc:-1, words:4, e_long:0, e_short:0, e_size:0, e_ovf:0};
    tv[1] = '{nl:2, l0:9, l1:8, l2:0, full_pc:-1, words:4, e_long:1, e_short:0, e_size:0, e_ovf:0};
    tv[2] = '{nl:2, l0:6, l1:8, l2:0, full_pc:-1, words:3, e_long:0, e_short:1, e_size:0, e_ovf:0};
    tv[3] = '{nl:3, l0:8, l1:8, l2:8, full_pc:-1, words:4, e_long:0, e_short:1, e_size:1, e_ovf:0};
    tv[4] = '{nl:2, l0:8, l1:8, l2:0, full_pc:7,  words:3, e_long:0, e_short:0, e_size:0, e_ovf:1};
    tv[5] = '{nl:1, l0:8, l1:0, l2:0, full_pc:-1, words:2, e_long:0, e_short:0, e_size:1, e_ovf:0};
    t1_words = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

    nRST = 1'b0; pix_en = 1'b0; line_valid = 1'b0; frame_valid = 1'b0; pixel_in = '0;
    new_addr = 1'b0; single_shot = 1'b0; fifo_full = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_w_e", w_e, 0);
    chk("rst_pixels_out", pixels_out, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk_flags("rst");
    nRST = 1'b1;
    tick();

    // new_addr arrives mid-frame: that frame is skipped, the next one is captured
    g_duty = 1; g_seq = 1; g_fall = 0; g_rand_full = 0;
    set_frame(2, 8, 8, 0);
    g_cap = 0; g_addr_pc = 3;
    run_frame();
    g_addr_pc = -1;
    wlog.delete();
    g_cap = 1;
    run_frame();
    chk_t1_words("t1");

    for (int v = 0; v < 6; v++) begin
      clear_errs();
      set_frame(tv[v].nl, tv[v].l0, tv[v].l1, tv[v].l2);
      g_full_pc = tv[v].full_pc;
      wlog.delete();
      run_frame();
      chk("vec_words", wlog.size(), tv[v].words);
      chk("vec_long",  err_line_long,  tv[v].e_long);
      chk("vec_short", err_line_short, tv[v].e_short);
      chk("vec_size",  err_frame_size, tv[v].e_size);
      chk("vec_ovf",   err_overflow,   tv[v].e_ovf);
    end
    g_full_pc = -1;

    // err_clr on the same sample that overruns the line: the new error survives
    set_frame(2, 9, 8, 0);
    g_clr_pc = 8;
    run_frame();
    g_clr_pc = -1;
    chk("setwins_long", err_line_long, 1);
    chk("setwins_size", err_frame_size, 0);

    g_seq = 0; g_rand_full = 1;
    for (int f = 0; f < 25; f++) begin
      g_duty = $urandom_range(1, 3);
      g_fall = 1'($urandom);
      g_nl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : HEIGHT;
      for (int l = 0; l < 4; l++)
        g_lens[l] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : WIDTH;
      g_clr_pc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
      run_frame();
    end
    g_clr_pc = -1; g_rand_full = 0; g_fall = 0; g_duty = 1;

    // reset on the sample that completes word 2: that write never appears
    set_frame(2, 8, 8, 0);
    g_seq = 1; g_rst_pc = 7;
    wlog.delete();
    run_frame();
    g_rst_pc = -1;
    chk("rst_mid_words", wlog.size(), 1);

    single_shot = 1'b1;
    new_addr = 1'b1;
    tick();
    new_addr = 1'b0;
    g_duty = 4; g_cap = 1;
    wlog.delete();
    run_frame();
    chk_t1_words("single_shot");
    g_cap = 0;
    run_frame();
    chk("single_shot_idle_words", wlog.size(), 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
